mfcc_frame_packer: RTL
======================

// Module: mfcc_frame_packer
// PURPOSE
//   Feature-side front end for the ASR accelerator. Collects a serial stream of
//   16-bit MFCC coefficients into complete 40-feature frames and presents each
//   frame in parallel to the Conv1D/LSTM datapath.
//   Double-buffered: one bank fills while the other waits for the accelerator.
//   Malformed frames are dropped, so the accelerator only ever sees whole frames.
// PARAMETERS
//   FEAT_W    16  width of one MFCC coefficient (signed, passed through unmodified)
//   NUM_FEAT  40  coefficients per frame
//   CNT_W     16  width of frame_count
// PORTS
//   clk          in   1                one clock domain
//   reset_n      in   1                synchronous, active-low reset
//   s_valid      in   1                coefficient stream valid
//   s_ready      out  1                packer can accept a coefficient
//   s_data       in   FEAT_W           coefficient value
//   s_last       in   1                marks the final coefficient of a frame
//   frame_valid  out  1                complete frame available
//   frame_ready  in   1                accelerator accepts frame
//   frame_data   out  NUM_FEAT*FEAT_W  feature i at [i*FEAT_W +: FEAT_W]
//   frame_err    out  1                1-cycle pulse when a malformed frame is dropped
//   frame_count  out  CNT_W            frames delivered; wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (reset_n==0 at a clk edge):
//     - state<=FILL, wr_idx<=0, wr_bank<=0, rd_bank<=0, full[1:0]<=0
//     - frame_err<=0, frame_count<=0, error counter<=0
//     - s_ready and frame_valid are forced 0 while reset_n==0
//     - bank contents are not cleared; frame_data is don't-care while frame_valid==0
//     - Reset mid-frame discards the partial frame and both banks.
//   Input handshake:
//     - A word is accepted on a cycle with s_valid && s_ready.
//     - s_ready = reset_n && (state==DROP || !full[wr_bank]).
//     - s_data/s_last may change freely while s_valid==0.
//   FSM
//     FILL:
//       - Accepted word is written to bank[wr_bank][wr_idx].
//       - s_last && wr_idx==NUM_FEAT-1: frame complete. full[wr_bank]<=1,
//         wr_bank toggles, wr_idx<=0.
//       - s_last && wr_idx<NUM_FEAT-1: short frame. wr_idx<=0, frame_err pulses,
//         bank stays empty.
//       - !s_last && wr_idx==NUM_FEAT-1: long frame. Go to DROP, wr_idx<=0,
//         bank stays empty.
//       - Otherwise: wr_idx++.
//     DROP:
//       - s_ready=1; accepted words are discarded.
//       - An accepted s_last pulses frame_err and returns to FILL.
//   Output handshake:
//     - frame_valid = full[rd_bank].
//     - frame_data = bank[rd_bank], muxed from registers (no added latency).
//     - On frame_valid && frame_ready: full[rd_bank]<=0, rd_bank toggles,
//       frame_count++.
//     - frame_valid/frame_data must hold stable until the frame is taken.
//   Latency:
//     - Final word accepted at edge N -> frame_valid=1 during cycle after N.
//     - A frame is emitted no earlier than NUM_FEAT cycles after its first word.
//   Concurrency:
//     - Fill-complete and output-take in the same cycle always touch different
//       banks (set requires !full, clear requires full); both take effect.
//   Backpressure:
//     - Both banks full -> s_ready=0 in FILL. No word is ever lost or overwritten.
//   frame_err:
//     - Registered; high for exactly 1 cycle per dropped frame.
// CONFIGURATION
//   PACKER_ERR_CNT_EN defined:
//     - Adds output err_count (8 bits): a saturating count of frame_err pulses.
//     - Holds at 255; cleared only by reset.
//   PACKER_ERR_CNT_EN undefined:
//     - Port and counter are absent; all other behaviour is identical.
// TESTING
//   1. After reset, stream 40 words 0x0000..0x0027 (s_last on the 40th), frame_ready=1
//      -> frame_valid for 1 cycle the cycle after the last word; feature i == i;
//      frame_count=1.
//   2. frame_ready=0, stream 3 full frames back-to-back
//      -> s_ready=0 from the first word of frame 3. Then raise frame_ready
//      -> frames 1, 2, 3 delivered in order with correct data.
//   3. s_last on word 10 -> frame_err pulses once, no frame_valid.
//      Then a valid 40-word frame -> delivered intact; err_count=1 if enabled.
//   4. 45 words with s_last only on the 45th -> one frame_err pulse after word 45,
//      no frame output. The next clean frame is delivered.
//   5. Assert reset_n=0 after word 20 of a frame, with one full bank pending
//      -> frame_valid=0, frame_count=0. A new 40-word frame is delivered correctly.
//   6. 256 frame_count wrap with CNT_W=8 override -> count returns to 0.
//      Drop 300 short frames -> err_count saturates at 255.

Source files
------------

// File: rtl/mfcc_frame_packer.sv
// Packs a serial MFCC coefficient stream into double-buffered NUM_FEAT-wide frames.
// Optional feature: define PACKER_ERR_CNT_EN to add a saturating 8-bit err_count output.
module mfcc_frame_packer #(
    parameter int FEAT_W   = 16,
    parameter int NUM_FEAT = 40,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [FEAT_W-1:0]            s_data,
    input  logic                         s_last,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [NUM_FEAT*FEAT_W-1:0]   frame_data,
    output logic                         frame_err,
`ifdef PACKER_ERR_CNT_EN
    output logic [7:0]                   err_count,
`endif
    output logic [CNT_W-1:0]             frame_count
);

    // Handshakes: a word moves on s_valid && s_ready, a frame on frame_valid && frame_ready;
    // the producer holds valid and its payload stable until the matching ready completes the transfer.

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              wr_idx, wr_idx_nxt;
    logic                          wr_bank, rd_bank;
    logic [1:0]                    full;
    logic [NUM_FEAT*FEAT_W-1:0]    bank_q [2];

    logic accept, take, write_en, set_full, err_nxt;
    logic [1:0] set_mask, clr_mask;

    assign s_ready     = reset_n && (state == DROP || !full[wr_bank]);
    assign frame_valid = reset_n && full[rd_bank];
    assign frame_data  = bank_q[rd_bank];
    assign accept      = s_valid && s_ready;
    assign take        = frame_valid && frame_ready;

    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        write_en   = 1'b0;
        set_full   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    write_en = 1'b1;
                    if (s_last) begin
                        wr_idx_nxt = '0;
                        if (wr_idx == LAST_IDX) begin
                            set_full = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (wr_idx == LAST_IDX) begin
                        // Too long: swallow the rest of this frame up to its s_last.
                        state_nxt  = DROP;
                        wr_idx_nxt = '0;
                    end else begin
                        wr_idx_nxt = wr_idx + 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    err_nxt   = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Set needs !full and clear needs full, so the two masks never hit the same bank.
    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (set_full) set_mask[wr_bank] = 1'b1;
        if (take)     clr_mask[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FILL;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_nxt;
            wr_idx    <= wr_idx_nxt;
            frame_err <= err_nxt;
            full      <= (full | set_mask) & ~clr_mask;
            if (set_full) wr_bank <= ~wr_bank;
            if (take) begin
                rd_bank     <= ~rd_bank;
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Bank storage has no reset; contents are only observable behind frame_valid.
    always_ff @(posedge clk) begin
        if (write_en) begin
            bank_q[wr_bank][wr_idx*FEAT_W +: FEAT_W] <= s_data;
        end
    end

`ifdef PACKER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (frame_err && err_count != 8'hFF) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
